// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with RV32M decode and a mul/div sequencing FSM.
// Base ops present one cycle after accept; M ops dwell in EXEC for their latency first.
module alu_ctrl_seq #(
  parameter int M_EXT      = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CTRL_W     = 5,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              opcodeb5,
  input  logic [1:0]        ALU_op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALU_control,
  output logic              md_start,
  output logic              md_busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_OUT
  } state_t;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_SLT   = 5'b00100;
  localparam logic [4:0] OP_SLTU  = 5'b00101;
  localparam logic [4:0] OP_XOR   = 5'b00110;
  localparam logic [4:0] OP_LUI   = 5'b00111;
  localparam logic [4:0] OP_SLL   = 5'b01000;
  localparam logic [4:0] OP_SRA   = 5'b01001;
  localparam logic [4:0] OP_SRL   = 5'b01010;
  localparam logic [4:0] OP_AUIPC = 5'b01011;

  localparam bit              M_ON     = (M_EXT != 0);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [4:0]       code;
  logic             dec_illegal;
  logic             dec_is_m;
  logic             ready;
  logic             accept;

  // Instruction decode; every path yields a defined word so nothing downstream sees X.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    code        = OP_ADD;
    dec_illegal = 1'b0;
    dec_is_m    = 1'b0;
    case (ALU_op)
      2'b00: code = OP_ADD;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: code = OP_SUB;
          3'b100, 3'b101: code = OP_SLT;
          3'b110, 3'b111: code = OP_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (opcodeb5 && funct7b0) begin
          if (M_ON) begin
            code     = {2'b10, funct3};
            dec_is_m = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          case (funct3)
            3'b000:  code = (funct7b5 && opcodeb5) ? OP_SUB : OP_ADD;
            3'b001:  code = OP_SLL;
            3'b010:  code = OP_SLT;
            3'b011:  code = OP_SLTU;
            3'b100:  code = OP_XOR;
            3'b101:  code = funct7b5 ? OP_SRA : OP_SRL;
            3'b110:  code = OP_OR;
            default: code = OP_AND;
          endcase
        end
      end
      default: code = opcodeb5 ? OP_LUI : OP_AUIPC;
    endcase
  end

  // Next-state logic; flush overrides every transition and blocks acceptance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cycle_cnt;
    ready     = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_EXEC: begin
        if (cycle_cnt == '0) state_nxt = S_OUT;
        else                 cnt_nxt   = cycle_cnt - 1'b1;
      end
      S_OUT: begin
        ready = out_ready;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (flush) ready = 1'b0;
    accept = in_valid && ready;

    if (accept) begin
      if (dec_is_m) begin
        state_nxt = S_EXEC;
        cnt_nxt   = funct3[2] ? DIV_LAST : MUL_LAST;
      end else begin
        state_nxt = S_OUT;
      end
    end

    if (flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cycle_cnt   <= '0;
      ALU_control <= '0;
      illegal     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cycle_cnt <= cnt_nxt;
      if (accept) begin
        ALU_control <= CTRL_W'(code);
        illegal     <= dec_illegal;
      end
    end
  end

  assign in_ready  = ready;
  assign out_valid = (state == S_OUT);
  assign md_busy   = (state == S_EXEC);
  assign md_start  = accept && dec_is_m;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: an M-enabled and an M-disabled instance share stimulus and are
// compared every cycle against a transaction-level reference model, plus directed checks.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 20;
  localparam int DIV_LAT = 33;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, in_valid, opcodeb5, funct7b5, funct7b0, out_ready;
  logic [1:0] ALU_op;
  logic [2:0] funct3;

  logic       r1, ov1, ms1, mb1, il1;
  logic [4:0] ctl1;
  logic [5:0] cc1;
  logic       r0, ov0, ms0, mb0, il0;
  logic [4:0] ctl0;
  logic [5:0] cc0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.M_EXT(1), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT), .CTRL_W(5), .CNT_W(6)) u_m1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .opcodeb5(opcodeb5), .ALU_op(ALU_op), .funct3(funct3), .funct7b5(funct7b5),
    .funct7b0(funct7b0), .out_valid(ov1), .out_ready(out_ready), .ALU_control(ctl1),
    .md_start(ms1), .md_busy(mb1), .cycle_cnt(cc1), .illegal(il1)
  );

  alu_ctrl_seq #(.M_EXT(0), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT), .CTRL_W(5), .CNT_W(6)) u_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r0),
    .opcodeb5(opcodeb5), .ALU_op(ALU_op), .funct3(funct3), .funct7b5(funct7b5),
    .funct7b0(funct7b0), .out_valid(ov0), .out_ready(out_ready), .ALU_control(ctl0),
    .md_start(ms0), .md_busy(mb0), .cycle_cnt(cc0), .illegal(il0)
  );

  // Reference model: one outstanding result, an optional countdown of execute cycles.
  typedef struct {
    int         busy_left;
    bit         have;
    logic [4:0] word;
    bit         ill;
  } mdl_t;

  mdl_t m1, m0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input bit m_ext, output logic [4:0] w, output bit ill,
                                     output bit is_m);
    int tbl[8];
    tbl  = '{0, 8, 4, 5, 6, 10, 3, 2};
    w    = 5'd0;
    ill  = 1'b0;
    is_m = 1'b0;
    if (ALU_op == 2'd1) begin
      if (funct3 == 3'd2 || funct3 == 3'd3) ill = 1'b1;
      else w = (funct3 < 3'd2) ? 5'd1 : ((funct3 < 3'd6) ? 5'd4 : 5'd5);
    end else if (ALU_op == 2'd3) begin
      w = opcodeb5 ? 5'd7 : 5'd11;
    end else if (ALU_op == 2'd2) begin
      if (opcodeb5 && funct7b0) begin
        if (m_ext) begin
          w    = 5'(16 + int'(funct3));
          is_m = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end else begin
        w = 5'(tbl[funct3]);
        if (funct3 == 3'd0 && funct7b5 && opcodeb5) w = 5'd1;
        if (funct3 == 3'd5 && funct7b5) w = 5'd9;
      end
    end
  endfunction

  function automatic bit exp_ready(input mdl_t m);
    return !flush && (m.busy_left == 0) && (!m.have || out_ready);
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit m_ext);
    mdl_t       n;
    bit         acc, ill, is_m;
    logic [4:0] w;
    n   = m;
    acc = in_valid && exp_ready(m);
    ref_decode(m_ext, w, ill, is_m);
    if (flush) begin
      n.busy_left = 0;
      n.have      = 1'b0;
      return n;
    end
    if (m.busy_left > 0) n.busy_left = m.busy_left - 1;
    else if (m.have && out_ready) n.have = 1'b0;
    if (acc) begin
      n.word      = w;
      n.ill       = ill;
      n.have      = 1'b1;
      n.busy_left = is_m ? (funct3[2] ? DIV_LAT : MUL_LAT) : 0;
    end
    return n;
  endfunction

  task automatic check_inst(input string n, input mdl_t m, input bit m_ext, input logic rdy,
                            input logic ov, input logic mb, input logic ms, input logic il,
                            input logic [5:0] cc, input logic [4:0] ctl);
    bit         e_ov, e_rdy, ill, is_m;
    logic [4:0] w;
    e_ov  = m.have && (m.busy_left == 0);
    e_rdy = exp_ready(m);
    ref_decode(m_ext, w, ill, is_m);
    check({n, ".in_ready"}, 32'(rdy), 32'(e_rdy));
    check({n, ".out_valid"}, 32'(ov), 32'(e_ov));
    check({n, ".md_busy"}, 32'(mb), 32'(m.busy_left > 0));
    check({n, ".cycle_cnt"}, 32'(cc), (m.busy_left > 0) ? 32'(m.busy_left - 1) : 32'd0);
    check({n, ".md_start"}, 32'(ms), 32'(in_valid && e_rdy && is_m));
    if (e_ov || m.busy_left > 0) begin
      check({n, ".ALU_control"}, 32'(ctl), 32'(m.word));
      check({n, ".illegal"}, 32'(il), 32'(m.ill));
    end
  endtask

  // One clock: compare both instances mid-cycle, advance the model, return just after the edge.
  task automatic step();
    @(negedge clk);
    check_inst("m1", m1, 1'b1, r1, ov1, mb1, ms1, il1, cc1, ctl1);
    check_inst("m0", m0, 1'b0, r0, ov0, mb0, ms0, il0, cc0, ctl0);
    m1 = mdl_step(m1, 1'b1);
    m0 = mdl_step(m0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [2:0] f3, input bit f7b5,
                       input bit f7b0, input bit op5, input bit ordy, input bit fl);
    in_valid  = v;
    ALU_op    = op;
    funct3    = f3;
    funct7b5  = f7b5;
    funct7b0  = f7b0;
    opcodeb5  = op5;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic model_reset();
    m1 = '{busy_left: 0, have: 1'b0, word: 5'd0, ill: 1'b0};
    m0 = '{busy_left: 0, have: 1'b0, word: 5'd0, ill: 1'b0};
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    #12;
    check("rst.out_valid", 32'(ov1), 0);
    check("rst.ALU_control", 32'(ctl1), 0);
    check("rst.illegal", 32'(il1), 0);
    check("rst.md_busy", 32'(mb1), 0);
    check("rst.cycle_cnt", 32'(cc1), 0);
    check("rst.md_start", 32'(ms1), 0);
    check("rst.m0_out_valid", 32'(ov0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R-type sub
    drive(1, 2'b10, 3'b000, 1, 0, 1, 1, 0);
    step();
    check("sub.out_valid", 32'(ov1), 1);
    check("sub.ALU_control", 32'(ctl1), 32'h01);
    check("sub.illegal", 32'(il1), 0);

    // Back-to-back blt then auipc with no bubble
    drive(1, 2'b01, 3'b100, 0, 0, 0, 1, 0);
    step();
    check("b2b.blt", 32'(ctl1), 32'h04);
    drive(1, 2'b11, 3'b000, 0, 0, 0, 1, 0);
    #1;
    check("b2b.in_ready", 32'(r1), 1);
    step();
    check("b2b.auipc", 32'(ctl1), 32'h0B);
    check("b2b.out_valid", 32'(ov1), 1);
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    step();

    // DIV: 33 EXEC cycles counting 32 down to 0, result at accept+34
    drive(1, 2'b10, 3'b100, 0, 1, 1, 1, 0);
    #1;
    check("div.md_start", 32'(ms1), 1);
    step();
    check("div.m0_illegal", 32'(il0), 1);
    check("div.m0_ctrl", 32'(ctl0), 0);
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    for (int i = 0; i < DIV_LAT; i++) begin
      check("div.md_busy", 32'(mb1), 1);
      check("div.cycle_cnt", 32'(cc1), 32'(DIV_LAT - 1 - i));
      step();
    end
    check("div.out_valid", 32'(ov1), 1);
    check("div.ALU_control", 32'(ctl1), 32'h14);
    step();

    // Backpressure on a base op
    drive(1, 2'b10, 3'b100, 0, 0, 0, 1, 0);
    step();
    drive(1, 2'b10, 3'b111, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.in_ready", 32'(r1), 0);
      check("bp.out_valid", 32'(ov1), 1);
      check("bp.ALU_control", 32'(ctl1), 32'h06);
      step();
    end
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    step();
    check("bp.release", 32'(ov1), 0);

    // MUL flushed in its 10th EXEC cycle, then a plain add
    drive(1, 2'b10, 3'b000, 0, 1, 1, 1, 0);
    step();
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step();
    check("fl.cnt_before", 32'(cc1), 32'(MUL_LAT - 10));
    drive(1, 2'b00, 3'b000, 0, 0, 0, 1, 1);
    #1;
    check("fl.in_ready", 32'(r1), 0);
    step();
    check("fl.md_busy", 32'(mb1), 0);
    check("fl.out_valid", 32'(ov1), 0);
    check("fl.cycle_cnt", 32'(cc1), 0);
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    step();
    step();
    drive(1, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    step();
    check("fl.add_valid", 32'(ov1), 1);
    check("fl.add_ctrl", 32'(ctl1), 0);

    // Illegal branch funct3
    drive(1, 2'b01, 3'b010, 0, 0, 0, 1, 0);
    step();
    check("ill.branch", 32'(il1), 1);
    check("ill.branch_ctrl", 32'(ctl1), 0);
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 31) == 0);
      step();
    end

    // Asynchronous reset in the middle of EXEC
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 1);
    step();
    drive(1, 2'b10, 3'b110, 0, 1, 1, 1, 0);
    step();
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.md_busy", 32'(mb1), 0);
    check("arst.cycle_cnt", 32'(cc1), 0);
    check("arst.out_valid", 32'(ov1), 0);
    check("arst.ALU_control", 32'(ctl1), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 2'b11, 3'b000, 0, 0, 1, 1, 0);
    step();
    check("arst.lui", 32'(ctl1), 32'h07);
    drive(0, 2'b00, 3'b000, 0, 0, 0, 1, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
